mem_arbiter_n: RTL

- Parametrised N-client successor to the two-port icache/dcache arbiter.
- Multiplexes NUM_CLIENTS cache request channels and their write-data channels onto the single main-memory request interface.
- Encodes the client index into mem_req_tag and routes each response valid back to the owning client by tag.
- Sits between the cache instances and ExtMemModel/main memory inside the memory subsystem wrapper.

---
 rtl/mem_arbiter_n.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: multiplexes NUM_CLIENTS cache request/write-data channels onto one main-memory request port
//   clk, reset (sync, active-low)
//   cl_req_*           : per-client request, write-data and ready vectors (packed, client i at slice i)
//   cl_resp_valid      : one-hot response valid, routed by mem_resp_tag
//   mem_req_*          : single memory request + write-data channel, tag = granted client index
//   mem_resp_valid/tag : memory response notification
//   Optional macro MEM_ARB_RR_EN selects round-robin arbitration; otherwise fixed priority (lowest index).
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 64
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 4
`endif
module mem_arbiter_n #(
  parameter int NUM_CLIENTS = 2,
  parameter int CLIENT_BITS = 1,
  parameter int ADDR_W      = `MEM_ADDR_BITS,
  parameter int DATA_W      = `MEM_DATA_BITS,
  parameter int TAG_W       = `MEM_TAG_BITS,
  parameter int DATA_BEATS  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CLIENTS-1:0]        cl_req_valid,
  output logic [NUM_CLIENTS-1:0]        cl_req_ready,
  input  logic [NUM_CLIENTS-1:0]        cl_req_rw,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_req_addr,
  input  logic [NUM_CLIENTS-1:0]        cl_req_data_valid,
  output logic [NUM_CLIENTS-1:0]        cl_req_data_ready,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cl_req_data_bits,
  input  logic [NUM_CLIENTS*DATA_W/8-1:0] cl_req_data_mask,
  output logic [NUM_CLIENTS-1:0]        cl_resp_valid,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic                          mem_req_rw,
  output logic [ADDR_W-1:0]             mem_req_addr,
  output logic [TAG_W-1:0]              mem_req_tag,
  output logic                          mem_req_data_valid,
  input  logic                          mem_req_data_ready,
  output logic [DATA_W-1:0]             mem_req_data_bits,
  output logic [DATA_W/8-1:0]           mem_req_data_mask,
  input  logic                          mem_resp_valid,
  input  logic [TAG_W-1:0]              mem_resp_tag
);
  localparam int MASK_W = DATA_W / 8;
  localparam int BEAT_W = DATA_BEATS > 1 ? $clog2(DATA_BEATS) : 1;
  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WDATA = 2'd2;
  logic [1:0]             r_state;
  logic [CLIENT_BITS-1:0] r_grant;
  logic [BEAT_W-1:0]      r_beat_cnt;
  logic [CLIENT_BITS-1:0] w_win;
  logic                   w_issue, w_wdata, w_beat_hs, w_last_beat;
`ifdef MEM_ARB_RR_EN
  logic [CLIENT_BITS-1:0] r_rr_ptr;
  logic                   w_req_hs;
`endif
  // First pass finds the lowest valid client; with round-robin a second pass
  // overrides it with the lowest valid client at or above the pointer, which
  // together give a search starting at rr_ptr that wraps modulo NUM_CLIENTS.
  always_comb begin
    w_win = '0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--)
      if (cl_req_valid[i]) w_win = CLIENT_BITS'(i);
`ifdef MEM_ARB_RR_EN
    for (int i = NUM_CLIENTS - 1; i >= 0; i--)
      if (cl_req_valid[i] && CLIENT_BITS'(i) >= r_rr_ptr) w_win = CLIENT_BITS'(i);
`endif
  end
  assign w_issue            = r_state == ST_ISSUE;
  assign w_wdata            = r_state == ST_WDATA;
  assign mem_req_valid      = w_issue & cl_req_valid[r_grant];
  assign mem_req_rw         = w_issue & cl_req_rw[r_grant];
  assign mem_req_addr       = w_issue ? cl_req_addr[r_grant*ADDR_W +: ADDR_W] : '0;
  assign mem_req_tag        = w_issue ? TAG_W'(r_grant) : '0;
  assign cl_req_ready       = w_issue ? NUM_CLIENTS'(mem_req_ready) << r_grant : '0;
  assign mem_req_data_valid = w_wdata & cl_req_data_valid[r_grant];
  assign mem_req_data_bits  = w_wdata ? cl_req_data_bits[r_grant*DATA_W +: DATA_W] : '0;
  assign mem_req_data_mask  = w_wdata ? cl_req_data_mask[r_grant*MASK_W +: MASK_W] : '0;
  assign cl_req_data_ready  = w_wdata ? NUM_CLIENTS'(mem_req_data_ready) << r_grant : '0;
  assign w_beat_hs          = mem_req_data_valid & mem_req_data_ready;
  assign w_last_beat        = r_beat_cnt == BEAT_W'(DATA_BEATS - 1);
  // Tags with any bit set above the client index cannot belong to a client and are dropped;
  // an in-range index beyond NUM_CLIENTS-1 is shifted out of the vector and dropped too.
  assign cl_resp_valid = (mem_resp_valid && (mem_resp_tag >> CLIENT_BITS) == '0) ?
                         NUM_CLIENTS'(1) << mem_resp_tag[CLIENT_BITS-1:0] : '0;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_ARB;
      r_grant    <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_ARB: begin
          if (|cl_req_valid) begin
            r_grant <= w_win;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_beat_cnt <= '0;
          r_state    <= !cl_req_valid[r_grant] ? ST_ARB :
                        !mem_req_ready         ? ST_ISSUE :
                        cl_req_rw[r_grant]     ? ST_WDATA : ST_ARB;
        end
        ST_WDATA: begin
          if (w_beat_hs) begin
            r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
            if (w_last_beat) r_state <= ST_ARB;
          end
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end
`ifdef MEM_ARB_RR_EN
  assign w_req_hs = mem_req_valid & mem_req_ready;
  always_ff @(posedge clk) begin
    if (!reset) r_rr_ptr <= '0;
    else if (w_req_hs) r_rr_ptr <= r_grant == CLIENT_BITS'(NUM_CLIENTS - 1) ? '0 : r_grant + 1'b1;
  end
`endif
endmodule
